// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift/add multiply and
// restoring divide, sharing one XLEN+1-bit adder, with a one-cycle sign fix-up.
module muldiv_seq #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            kill,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    state_t            state_nx;
    logic              accept;
    logic [CNT_W-1:0]  count;

    // Latched operation context and the hi:lo accumulator.
    logic [2:0]        op_funct;
    logic              op_neg;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;

    // Request-side operand conditioning.
    logic              is_div;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic              res_neg;
    logic              div_zero;
    logic              div_ovf;
    logic              fast;
    logic [XLEN-1:0]   fast_data;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        is_div    = req_funct[2];
        a_neg     = 1'b0;
        b_neg     = 1'b0;
        fast_data = '0;
        if (is_div) begin
            a_neg = ~req_funct[0] & req_a[XLEN-1];
            b_neg = ~req_funct[0] & req_b[XLEN-1];
        end else begin
            a_neg = (req_funct[1:0] != 2'd3) & req_a[XLEN-1];
            b_neg = ~req_funct[1] & req_b[XLEN-1];
        end
        a_abs    = a_neg ? -req_a : req_a;
        b_abs    = b_neg ? -req_b : req_b;
        // Remainder follows the dividend sign; everything else takes the XOR.
        res_neg  = (is_div && req_funct[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (req_b == '0);
        div_ovf  = is_div && !req_funct[0] && (req_a == MIN_INT) && (req_b == '1);
        fast     = div_zero || div_ovf;
        if (div_zero) begin
            fast_data = req_funct[1] ? req_a : '1;
        end else if (div_ovf) begin
            fast_data = req_funct[1] ? '0 : MIN_INT;
        end
    end

    // Shared adder: add multiplicand (MUL*) or subtract divisor (DIV*/REM*).
    logic              op_div;
    logic [XLEN:0]     shift_rem;
    logic [XLEN:0]     add_x;
    logic [XLEN:0]     add_y;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     partial;
    logic              q_bit;
    logic [XLEN-1:0]   hi_nx;
    logic [XLEN-1:0]   lo_nx;

    always_comb begin
        op_div    = op_funct[2];
        shift_rem = {acc_hi, acc_lo[XLEN-1]};
        add_x     = op_div ? shift_rem : {1'b0, acc_hi};
        add_y     = op_div ? ~{1'b0, op_b} : {1'b0, op_b};
        add_sum   = add_x + add_y + {{XLEN{1'b0}}, op_div};
        partial   = acc_lo[0] ? add_sum : {1'b0, acc_hi};
        q_bit     = ~add_sum[XLEN];
        hi_nx     = acc_hi;
        lo_nx     = acc_lo;
        if (op_div) begin
            hi_nx = q_bit ? add_sum[XLEN-1:0] : shift_rem[XLEN-1:0];
            lo_nx = {acc_lo[XLEN-2:0], q_bit};
        end else begin
            {hi_nx, lo_nx} = {partial, acc_lo[XLEN-1:1]};
        end
    end

    // Sign fix-up and half selection.
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_data;

    always_comb begin
        prod   = {acc_hi, acc_lo};
        prod_s = op_neg ? -prod : prod;
        quot_s = op_neg ? -acc_lo : acc_lo;
        rem_s  = op_neg ? -acc_hi : acc_hi;
        case (op_funct)
            3'd0:                fix_data = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_data = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fix_data = quot_s;
            default:             fix_data = rem_s;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = fast ? S_DONE : S_BUSY;
            S_BUSY: if (count == '0) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: if (resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (kill) begin
            state_nx = S_IDLE;
        end
    end

    // Outputs.
    always_comb begin
        req_ready  = reset_n && (state == S_IDLE) && !kill;
        resp_valid = (state == S_DONE);
        accept     = req_valid && req_ready;
    end

    // Control-visible registers: reset so the response port is clean.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count     <= '0;
            resp_data <= '0;
        end else begin
            if (accept) begin
                count <= CNT_W'(XLEN - 1);
                if (fast) begin
                    resp_data <= fast_data;
                end
            end else if (state == S_BUSY) begin
                count <= count - 1'b1;
            end else if (state == S_FIX) begin
                resp_data <= fix_data;
            end
        end
    end

    // NOTE: pure datapath registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_funct <= req_funct;
            op_neg   <= res_neg;
            op_b     <= b_abs;
            acc_hi   <= '0;
            acc_lo   <= a_abs;
        end else if (state == S_BUSY) begin
            acc_hi   <= hi_nx;
            acc_lo   <= lo_nx;
        end
    end

endmodule
